// File: rtl/tcb_rr_arbiter.sv
// Shares one TCB subordinate between MPN managers, in round-robin or fixed-priority mode.
// A stalled request locks the grant; each response is routed back through a DLY-deep index pipeline.
module tcb_rr_arbiter #(
    parameter int unsigned MPN = 2,
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned DLY = 1,
    parameter bit          RRB = 1'b1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MPN-1:0]          man_vld,
    input  logic [MPN-1:0]          man_wen,
    input  logic [MPN-1:0][ABW-1:0] man_adr,
    input  logic [MPN-1:0][2:0]     man_fn3,
    input  logic [MPN-1:0][DBW-1:0] man_wdt,
    output logic [MPN-1:0]          man_rdy,
    output logic [DBW-1:0]          man_rdt,
    output logic [MPN-1:0]          man_err,
    output logic                    sub_vld,
    output logic                    sub_wen,
    output logic [ABW-1:0]          sub_adr,
    output logic [2:0]              sub_fn3,
    output logic [DBW-1:0]          sub_wdt,
    input  logic                    sub_rdy,
    input  logic [DBW-1:0]          sub_rdt,
    input  logic                    sub_err
);

    localparam int unsigned IW = (MPN > 1) ? $clog2(MPN) : 1;

    logic [IW-1:0] gnt;
    logic          gnt_any;
    logic [IW-1:0] ptr;
    logic          lck;
    logic [IW-1:0] lck_idx;
    logic [IW:0]   scan;
    logic          xfer;
    logic          rsp_vld;
    logic [IW-1:0] rsp_idx;

    // Grant: locked owner first, else scan from ptr (round-robin) or from index 0 (fixed).
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        scan    = '0;
        if (lck) begin
            gnt     = lck_idx;
            gnt_any = 1'b1;
        end else if (RRB) begin
            for (int k = 0; k < int'(MPN); k++) begin
                scan = {1'b0, ptr} + (IW+1)'(k);
                if (scan >= (IW+1)'(MPN)) begin
                    scan = scan - (IW+1)'(MPN);
                end
                if (!gnt_any && man_vld[scan[IW-1:0]]) begin
                    gnt     = scan[IW-1:0];
                    gnt_any = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < int'(MPN); k++) begin
                if (!gnt_any && man_vld[IW'(k)]) begin
                    gnt     = IW'(k);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign sub_vld = gnt_any & man_vld[gnt];
    assign sub_wen = man_wen[gnt];
    assign sub_adr = man_adr[gnt];
    assign sub_fn3 = man_fn3[gnt];
    assign sub_wdt = man_wdt[gnt];
    assign xfer    = sub_vld & sub_rdy;

    always_comb begin
        man_rdy = '0;
        for (int i = 0; i < int'(MPN); i++) begin
            man_rdy[i] = xfer & (gnt == IW'(i));
        end
    end

    // Lock holds a stalled grant; ptr moves past the manager that just transferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lck     <= 1'b0;
            lck_idx <= '0;
            ptr     <= '0;
        end else begin
            if (sub_vld && !sub_rdy) begin
                lck     <= 1'b1;
                lck_idx <= gnt;
            end else if (xfer) begin
                lck     <= 1'b0;
            end
            if (xfer) begin
                ptr <= (gnt == IW'(MPN-1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    generate
        if (DLY == 0) begin : g_rsp_comb
            assign rsp_vld = xfer;
            assign rsp_idx = gnt;
        end else begin : g_rsp_pipe
            logic [DLY-1:0]         rsp_vld_p;
            logic [DLY-1:0][IW-1:0] rsp_idx_p;

            // Response stage boundary: valid is reset, the owner index is plain data.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rsp_vld_p <= '0;
                end else begin
                    rsp_vld_p[0] <= xfer;
                    for (int k = 1; k < int'(DLY); k++) begin
                        rsp_vld_p[k] <= rsp_vld_p[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                rsp_idx_p[0] <= gnt;
                for (int k = 1; k < int'(DLY); k++) begin
                    rsp_idx_p[k] <= rsp_idx_p[k-1];
                end
            end

            assign rsp_vld = rsp_vld_p[DLY-1];
            assign rsp_idx = rsp_idx_p[DLY-1];
        end
    endgenerate

    assign man_rdt = sub_rdt;

    always_comb begin
        man_err = '0;
        for (int i = 0; i < int'(MPN); i++) begin
            man_err[i] = sub_err & rsp_vld & (rsp_idx == IW'(i));
        end
    end

endmodule
